// File: rtl/nexys_starship_spawn_sched.sv
// Monster spawn scheduler: waits a level-dependent gap, picks a free terminal from an
// LFSR start point, requests a spawn there and waits a bounded time for the acknowledge.
module nexys_starship_spawn_sched #(
  parameter int         N_TERM        = 4,
  parameter int         BASE_GAP      = 6,
  parameter int         MAX_ACTIVE    = 2,
  parameter int         SPAWNS_PER_LV = 4,
  parameter int         ACK_TIMEOUT   = 4,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic              timer_clk,
  input  logic              Reset,
  input  logic              play_flag,
  input  logic              gameover,
  input  logic [N_TERM-1:0] term_full,
  output logic [N_TERM-1:0] spawn_req,
  output logic              spawn_drop,
  output logic [1:0]        level,
  output logic [7:0]        spawn_total,
  output logic              sched_busy
);

  localparam int IDX_W = (N_TERM > 1) ? $clog2(N_TERM) : 1;
  localparam int GAP_W = $clog2(BASE_GAP + 1);
  localparam int ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int LV_W  = (SPAWNS_PER_LV > 1) ? $clog2(SPAWNS_PER_LV) : 1;
  localparam int POP_W = $clog2(N_TERM + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_PICK,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t           state;
  logic [7:0]       lfsr;
  logic             lfsr_fb;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_len;
  logic [GAP_W-1:0] gap_step;
  logic [ACK_W-1:0] ack_cnt;
  logic [LV_W-1:0]  lv_cnt;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic [POP_W-1:0] full_cnt;
  logic             room;
  logic             abort;
  logic             ack;
  logic             timeout;

  assign lfsr_fb    = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign sched_busy = (state != S_IDLE);
  assign abort      = (state != S_IDLE) && (gameover || !play_flag);
  assign ack        = term_full[sel];
  assign timeout    = (ack_cnt == ACK_W'(ACK_TIMEOUT - 1));
  assign start      = lfsr[IDX_W-1:0];

  // Spacing shrinks by one tick per level but never below one tick.
  // NOTE: every combinational output gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gap_len = GAP_W'(1);
    if (BASE_GAP - int'(level) > 1) gap_len = GAP_W'(BASE_GAP - int'(level));
  end

  assign gap_step = (gap_cnt >= gap_len) ? gap_len : gap_cnt + GAP_W'(1);

  always_comb begin
    full_cnt = '0;
    for (int i = 0; i < N_TERM; i++) full_cnt = full_cnt + POP_W'(term_full[i]);
  end

  assign room = int'(full_cnt) < MAX_ACTIVE;

  // Walk the ring backwards so the candidate closest to start is the one kept;
  // the index sum wraps naturally at IDX_W bits because N_TERM is a power of two.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = N_TERM - 1; k >= 0; k--) begin
      if (!term_full[start + IDX_W'(k)]) begin
        pick_found = 1'b1;
        pick_idx   = start + IDX_W'(k);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge timer_clk or posedge Reset) begin
    if (Reset) begin
      state       <= S_IDLE;
      spawn_req   <= '0;
      spawn_drop  <= 1'b0;
      level       <= '0;
      spawn_total <= '0;
      gap_cnt     <= '0;
      ack_cnt     <= '0;
      lv_cnt      <= '0;
      sel         <= '0;
      lfsr        <= LFSR_SEED;
    end else begin
      lfsr       <= {lfsr[6:0], lfsr_fb};
      spawn_drop <= 1'b0;

      // Leaving play beats any ack or timeout seen on the same edge.
      if (abort || state == S_IDLE) begin
        spawn_req   <= '0;
        level       <= '0;
        spawn_total <= '0;
        gap_cnt     <= '0;
        ack_cnt     <= '0;
        lv_cnt      <= '0;
        state       <= (state == S_IDLE && play_flag && !gameover) ? S_GAP : S_IDLE;
      end else begin
        case (state)
          S_GAP: begin
            // The tick on which gap_cnt reaches gap_len is the last gap tick.
            gap_cnt <= gap_step;
            if (gap_step == gap_len && room) state <= S_PICK;
          end

          S_PICK: begin
            if (pick_found) begin
              sel   <= pick_idx;
              state <= S_ISSUE;
            end else begin
              gap_cnt <= '0;
              state   <= S_GAP;
            end
          end

          S_ISSUE: begin
            spawn_req <= N_TERM'(1) << sel;
            ack_cnt   <= '0;
            state     <= S_WAIT;
          end

          S_WAIT: begin
            if (ack) begin
              spawn_req   <= '0;
              spawn_total <= spawn_total + 8'd1;
              gap_cnt     <= '0;
              state       <= S_GAP;
              if (lv_cnt == LV_W'(SPAWNS_PER_LV - 1)) begin
                lv_cnt <= '0;
                if (level != 2'd3) level <= level + 2'd1;
              end else begin
                lv_cnt <= lv_cnt + LV_W'(1);
              end
            end else if (timeout) begin
              spawn_req  <= '0;
              spawn_drop <= 1'b1;
              gap_cnt    <= '0;
              state      <= S_GAP;
            end else begin
              ack_cnt <= ack_cnt + ACK_W'(1);
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nexys_starship_spawn_sched.sv
// Bench for the spawn scheduler: reset/idle vector table, directed corner sequences and
// randomized play compared every tick against a transaction-level reference model.
module tb_nexys_starship_spawn_sched;

  localparam int         N_TERM      = 4;
  localparam int         BASE_GAP    = 6;
  localparam int         MAX_ACTIVE  = 2;
  localparam int         SPL         = 4;
  localparam int         ACK_TIMEOUT = 4;
  localparam logic [7:0] SEED        = 8'hA5;

  logic       timer_clk = 1'b0;
  logic       Reset     = 1'b1;
  logic       play_flag = 1'b0;
  logic       gameover  = 1'b0;
  logic [3:0] term_full = 4'b0000;
  logic [3:0] spawn_req;
  logic       spawn_drop;
  logic [1:0] level;
  logic [7:0] spawn_total;
  logic       sched_busy;

  int checks = 0;
  int errors = 0;

  nexys_starship_spawn_sched #(
    .N_TERM       (N_TERM),
    .BASE_GAP     (BASE_GAP),
    .MAX_ACTIVE   (MAX_ACTIVE),
    .SPAWNS_PER_LV(SPL),
    .ACK_TIMEOUT  (ACK_TIMEOUT),
    .LFSR_SEED    (SEED)
  ) dut (
    .timer_clk  (timer_clk),
    .Reset      (Reset),
    .play_flag  (play_flag),
    .gameover   (gameover),
    .term_full  (term_full),
    .spawn_req  (spawn_req),
    .spawn_drop (spawn_drop),
    .level      (level),
    .spawn_total(spawn_total),
    .sched_busy (sched_busy)
  );

  always #5 timer_clk = ~timer_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (spawn-level view) ----------------
  typedef enum int {PH_IDLE, PH_GAP, PH_PICK, PH_ISSUE, PH_WAIT} phase_t;
  phase_t     m_ph;
  logic [7:0] m_lfsr;
  logic [7:0] m_pick_lfsr;
  int         m_gap_ticks;
  int         m_wait_ticks;
  int         m_acks;
  int         m_sel;
  logic [3:0] m_req;
  logic       m_drop;

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic int level_of(input int acks);
    return (acks / SPL > 3) ? 3 : acks / SPL;
  endfunction

  function automatic int gap_of(input int acks);
    return (BASE_GAP - level_of(acks) < 1) ? 1 : BASE_GAP - level_of(acks);
  endfunction

  function automatic int first_free(input int st, input logic [3:0] tf);
    for (int k = 0; k < N_TERM; k++) begin
      int idx = (st + k) % N_TERM;
      if (!tf[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ph = PH_IDLE; m_lfsr = SEED; m_pick_lfsr = SEED;
    m_gap_ticks = 0; m_wait_ticks = 0; m_acks = 0; m_sel = 0;
    m_req = '0; m_drop = 1'b0;
  endtask

  task automatic model_step(input logic pf, input logic go, input logic [3:0] tf);
    logic [7:0] l_now;
    int         f;
    l_now  = m_lfsr;
    m_lfsr = lfsr_next(m_lfsr);
    m_drop = 1'b0;
    if (m_ph != PH_IDLE && (go || !pf)) begin
      m_ph = PH_IDLE; m_acks = 0; m_req = '0;
      return;
    end
    case (m_ph)
      PH_IDLE: begin
        m_acks = 0; m_req = '0;
        if (pf && !go) begin m_ph = PH_GAP; m_gap_ticks = 0; end
      end
      PH_GAP: begin
        m_gap_ticks++;
        if (m_gap_ticks >= gap_of(m_acks) && $countones(tf) < MAX_ACTIVE) m_ph = PH_PICK;
      end
      PH_PICK: begin
        m_pick_lfsr = l_now;
        f = first_free(int'(l_now[1:0]), tf);
        if (f >= 0) begin m_sel = f; m_ph = PH_ISSUE; end
        else begin m_ph = PH_GAP; m_gap_ticks = 0; end
      end
      PH_ISSUE: begin
        m_req = 4'b0001 << m_sel; m_wait_ticks = 0; m_ph = PH_WAIT;
      end
      PH_WAIT: begin
        m_wait_ticks++;
        if (tf[m_sel]) begin
          m_acks++; m_req = '0; m_ph = PH_GAP; m_gap_ticks = 0;
        end else if (m_wait_ticks == ACK_TIMEOUT) begin
          m_req = '0; m_drop = 1'b1; m_ph = PH_GAP; m_gap_ticks = 0;
        end
      end
      default: m_ph = PH_IDLE;
    endcase
  endtask

  task automatic tick();
    @(posedge timer_clk);
    model_step(play_flag, gameover, term_full);
    #1;
    check("model_req",   32'(spawn_req),   32'(m_req));
    check("model_drop",  32'(spawn_drop),  32'(m_drop));
    check("model_level", 32'(level),       32'(level_of(m_acks)));
    check("model_total", 32'(spawn_total), 32'(m_acks % 256));
    check("model_busy",  32'(sched_busy),  32'(m_ph != PH_IDLE));
  endtask

  task automatic do_reset();
    Reset = 1'b1; play_flag = 1'b0; gameover = 1'b0; term_full = '0;
    @(posedge timer_clk);
    #1;
    model_reset();
    check("rst_req",   32'(spawn_req),   32'(0));
    check("rst_drop",  32'(spawn_drop),  32'(0));
    check("rst_level", 32'(level),       32'(0));
    check("rst_total", 32'(spawn_total), 32'(0));
    check("rst_busy",  32'(sched_busy),  32'(0));
    Reset = 1'b0;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (spawn_req == 4'b0000 && n < 40) begin
      tick();
      n++;
    end
    check("req_seen", 32'(spawn_req != 4'b0000), 32'(1));
  endtask

  typedef struct {
    logic       pf;
    logic       go;
    logic [3:0] tf;
    logic       exp_busy;
    logic [3:0] exp_req;
  } vec_t;

  vec_t vecs [14];

  initial begin
    int         n;
    int         held;
    logic       seen;
    logic [7:0] l;
    logic [7:0] nl;
    int         r;

    vecs[0]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000};
    vecs[1]  = '{1'b1, 1'b1, 4'b0000, 1'b0, 4'b0000};
    vecs[2]  = '{1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000};
    vecs[3]  = '{1'b1, 1'b0, 4'b1111, 1'b1, 4'b0000};
    vecs[4]  = '{1'b1, 1'b0, 4'b1111, 1'b1, 4'b0000};
    vecs[5]  = '{1'b1, 1'b0, 4'b1111, 1'b1, 4'b0000};
    vecs[6]  = '{1'b1, 1'b0, 4'b1111, 1'b1, 4'b0000};
    vecs[7]  = '{1'b1, 1'b0, 4'b1111, 1'b1, 4'b0000};
    vecs[8]  = '{1'b1, 1'b0, 4'b1111, 1'b1, 4'b0000};
    vecs[9]  = '{1'b1, 1'b0, 4'b1100, 1'b1, 4'b0000};
    vecs[10] = '{1'b1, 1'b0, 4'b1000, 1'b1, 4'b0000};
    vecs[11] = '{1'b1, 1'b0, 4'b1000, 1'b1, 4'b0000};
    vecs[12] = '{1'b1, 1'b1, 4'b1000, 1'b0, 4'b0000};
    vecs[13] = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000};

    // Table: idle gating, blocked gap (popcount == MAX_ACTIVE blocks), abort from ISSUE.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      play_flag = vecs[i].pf; gameover = vecs[i].go; term_full = vecs[i].tf;
      tick();
      check($sformatf("vec%0d_busy", i), 32'(sched_busy), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_req", i),  32'(spawn_req),  32'(vecs[i].exp_req));
    end

    // First spawn: 8 ticks after IDLE exit, aimed at the LFSR value seen during PICK.
    do_reset();
    play_flag = 1'b1; term_full = '0;
    tick();
    wait_req(n);
    check("first_latency", 32'(n), 32'(8));
    l = SEED;
    repeat (7) l = lfsr_next(l);
    check("first_target", 32'(spawn_req), 32'(4'b0001 << l[1:0]));
    tick();
    term_full = spawn_req;
    tick();
    term_full = '0;
    check("first_total", 32'(spawn_total), 32'(1));
    check("first_req_clear", 32'(spawn_req), 32'(0));

    // Level ramp: gaps 6,5,4,3 with immediate acks.
    do_reset();
    play_flag = 1'b1;
    tick();
    for (int k = 1; k <= 13; k++) begin
      wait_req(n);
      check($sformatf("gap_%0d", k), 32'(n - 2), 32'(6 - (k - 1) / 4));
      term_full = spawn_req;
      tick();
      term_full = '0;
      check($sformatf("level_%0d", k), 32'(level), 32'((k / 4 > 3) ? 3 : k / 4));
      check($sformatf("total_%0d", k), 32'(spawn_total), 32'(k));
    end

    // MAX_ACTIVE blocking, then release.
    do_reset();
    play_flag = 1'b1; term_full = 4'b0011;
    tick();
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (spawn_req != 4'b0000) seen = 1'b1;
    end
    check("blocked_no_req", 32'(seen), 32'(0));
    term_full = 4'b0010;
    wait_req(n);
    check("release_latency", 32'(n), 32'(3));
    check("release_target", 32'(spawn_req),
          32'(4'b0001 << first_free(int'(m_pick_lfsr[1:0]), 4'b0010)));
    term_full = 4'b0010 | spawn_req;
    tick();
    term_full = '0;

    // Timeout: request held 4 ticks, 1-tick drop, no count or level change.
    do_reset();
    play_flag = 1'b1;
    tick();
    wait_req(n);
    held = 1;
    while (held < 10) begin
      tick();
      if (spawn_req != 4'b0000) held++;
      else break;
    end
    check("timeout_held", 32'(held), 32'(4));
    check("timeout_drop", 32'(spawn_drop), 32'(1));
    tick();
    check("timeout_drop_pulse", 32'(spawn_drop), 32'(0));
    check("timeout_total", 32'(spawn_total), 32'(0));
    check("timeout_level", 32'(level), 32'(0));

    // Gameover and ack on the same edge: abort wins.
    do_reset();
    play_flag = 1'b1;
    tick();
    wait_req(n);
    term_full = spawn_req; gameover = 1'b1;
    tick();
    check("abort_busy",  32'(sched_busy),  32'(0));
    check("abort_req",   32'(spawn_req),   32'(0));
    check("abort_total", 32'(spawn_total), 32'(0));
    check("abort_level", 32'(level),       32'(0));
    check("abort_drop",  32'(spawn_drop),  32'(0));
    gameover = 1'b0; term_full = '0;

    // Scan wrap: start index 2 with 4'b1110 at PICK lands on index 0.
    do_reset();
    play_flag = 1'b1; term_full = 4'b0011;
    tick();
    repeat (10) tick();
    for (int g = 0; g < 64; g++) begin
      nl = lfsr_next(m_lfsr);
      if (nl[1:0] == 2'd2) break;
      tick();
    end
    nl = lfsr_next(m_lfsr);
    check("wrap_start", 32'(nl[1:0]), 32'(2));
    term_full = 4'b0000;
    tick();
    term_full = 4'b1110;
    tick();
    tick();
    check("wrap_req", 32'(spawn_req), 32'(4'b0001));
    tick();
    check("wrap_ignores_others", 32'(spawn_req), 32'(4'b0001));
    term_full = 4'b1111;
    tick();
    check("wrap_total", 32'(spawn_total), 32'(1));
    term_full = '0;

    // Reset asserted between edges mid-WAIT clears the request at once.
    do_reset();
    play_flag = 1'b1;
    tick();
    wait_req(n);
    #2 Reset = 1'b1;
    #1;
    check("async_rst_req",  32'(spawn_req),  32'(0));
    check("async_rst_busy", 32'(sched_busy), 32'(0));
    do_reset();

    // Randomized play against the reference model.
    play_flag = 1'b1;
    for (int t = 0; t < 3000; t++) begin
      r = int'($urandom_range(0, 7));
      if (r < 3)      term_full = 4'b0000;
      else if (r < 5) term_full = term_full | spawn_req;
      else            term_full = 4'($urandom_range(0, 15));
      play_flag = ($urandom_range(0, 63) != 0);
      gameover  = ($urandom_range(0, 63) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
